// File: rtl/player1_ctl.sv
// Player-1 per-frame motion/animation controller: walk, clamp-or-wrap at the
// screen edges, and a fixed-height jump. Define PLAYER1_CTL_WRAP_EN to wrap x instead of clamping.
package state_pkg;
  typedef enum logic [2:0] {IDLE, RIGHT1, RIGHT2, LEFT1, LEFT2} State;
endpackage

module player1_ctl #(
  parameter int X_START     = 100,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 984,
  parameter int STEP        = 4,
  parameter int Y_BASE      = 100,
  parameter int JUMP_H      = 96,
  parameter int JUMP_STEP   = 4,
  parameter int ANIM_FRAMES = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_jump,
  output logic [11:0]    xpos_player1,
  output logic [11:0]    ypos_player1,
  output state_pkg::State state,
  output logic           in_air
);
  import state_pkg::*;

  typedef enum logic [1:0] {GROUND, RISE, FALL} jump_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_R, DIR_L} dir_t;

  localparam logic [12:0] X_MIN13  = 13'(X_MIN);
  localparam logic [12:0] X_MAX13  = 13'(X_MAX);
  localparam logic [12:0] STEP13   = 13'(STEP);
  localparam logic [11:0] X_START12 = 12'(X_START);
  localparam logic [11:0] Y_BASE12 = 12'(Y_BASE);
  localparam logic [11:0] JS12     = 12'(JUMP_STEP);
  localparam logic [7:0]  JS8      = 8'(JUMP_STEP);
  localparam logic [7:0]  JH8      = 8'(JUMP_H);
  localparam logic [7:0]  ANIM_LAST = 8'(ANIM_FRAMES - 1);

  logic [11:0] x_q, x_d, y_q, y_d;
  logic [7:0]  h_q, h_d, cnt_q, cnt_d;
  logic        phase_q, phase_d;
  dir_t        dir_q, dir_d;
  jump_t       jst_q, jst_d;
  State        state_q, state_d;
  logic [12:0] x13;

  assign x13 = {1'b0, x_q};

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    jst_d   = jst_q;
    state_d = IDLE;
    dir_d   = DIR_NONE;
    if (btn_right && !btn_left) dir_d = DIR_R;
    else if (btn_left && !btn_right) dir_d = DIR_L;

    case (dir_d)
      DIR_R: begin
`ifdef PLAYER1_CTL_WRAP_EN
        if (x13 + STEP13 > X_MAX13) x_d = X_MIN13[11:0];
`else
        if (x13 + STEP13 > X_MAX13) x_d = X_MAX13[11:0];
`endif
        else x_d = 12'(x13 + STEP13);
      end
      DIR_L: begin
`ifdef PLAYER1_CTL_WRAP_EN
        if (x13 < X_MIN13 + STEP13) x_d = X_MAX13[11:0];
`else
        if (x13 < X_MIN13 + STEP13) x_d = X_MIN13[11:0];
`endif
        else x_d = 12'(x13 - STEP13);
      end
      default: x_d = x_q;
    endcase

    // A new (or no) direction restarts the walk cycle at phase 0.
    if (dir_d == DIR_NONE || dir_d != dir_q) begin
      cnt_d   = 8'd0;
      phase_d = 1'b0;
    end else if (cnt_q == ANIM_LAST) begin
      cnt_d   = 8'd0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    case (dir_d)
      DIR_R:   state_d = phase_d ? RIGHT2 : RIGHT1;
      DIR_L:   state_d = phase_d ? LEFT2 : LEFT1;
      default: state_d = IDLE;
    endcase

    // The triggering tick is already the first rising step.
    case (jst_q)
      GROUND: if (btn_jump) begin
        y_d   = y_q - JS12;
        h_d   = JS8;
        jst_d = (JS8 >= JH8) ? FALL : RISE;
      end
      RISE: begin
        y_d = y_q - JS12;
        h_d = h_q + JS8;
        if (h_q + JS8 == JH8) jst_d = FALL;
      end
      FALL: begin
        y_d = y_q + JS12;
        h_d = h_q - JS8;
        if (h_q - JS8 == 8'd0) begin
          jst_d = GROUND;
          y_d   = Y_BASE12;
        end
      end
      default: jst_d = GROUND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= X_START12;
      y_q     <= Y_BASE12;
      h_q     <= 8'd0;
      cnt_q   <= 8'd0;
      phase_q <= 1'b0;
      dir_q   <= DIR_NONE;
      jst_q   <= GROUND;
      state_q <= IDLE;
    end else if (frame_tick) begin
      x_q     <= x_d;
      y_q     <= y_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      jst_q   <= jst_d;
      state_q <= state_d;
    end
  end

  assign xpos_player1 = x_q;
  assign ypos_player1 = y_q;
  assign state        = state_q;
  assign in_air       = (jst_q != GROUND);
endmodule
